// File: rtl/biriscv_fetch_issue.sv
// biriscv_fetch_issue: issues icache reads from a local PC and buffers one bundle for decode.
// Redirects discard stale bundles and in-flight responses; a faulted fetch halts issue until redirect.
module biriscv_fetch_issue #(
    parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,
    output logic [1:0]  fetch_pred_branch_o,
    input  logic        fetch_accept_i
);
    localparam logic [31:0] BOOT_PC = {BOOT_VECTOR[31:3], 3'b000};

    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, out_pc_q, out_pc_d;
    logic [63:0] instr_q, instr_d;
    logic        outstanding_q, outstanding_d, drop_q, drop_d, halt_q, halt_d;
    logic        started_q, started_d, valid_q, valid_d, err_q, err_d, pf_q, pf_d;
    logic        req, rsp;

    always_comb begin
        icache_rd_o   = started_q & ~outstanding_q & ~halt_q & ~branch_request_i & (~valid_q | fetch_accept_i);
        req           = icache_rd_o & icache_accept_i;
        rsp           = icache_valid_i & outstanding_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        out_pc_d      = out_pc_q;
        instr_d       = instr_q;
        outstanding_d = rsp ? 1'b0 : (req | outstanding_q);
        drop_d        = drop_q;
        halt_d        = halt_q;
        started_d     = 1'b1;
        valid_d       = valid_q;
        err_d         = err_q;
        pf_d          = pf_q;
        if (req) begin
            pc_d     = {pc_q[31:3], 3'b000} + 32'd8;
            req_pc_d = pc_q;
        end
        // A response landing in the redirect cycle is consumed here, so no drop is armed for it.
        if (branch_request_i) begin
            valid_d = 1'b0;
            pc_d    = branch_pc_i;
            halt_d  = 1'b0;
            drop_d  = outstanding_q & ~icache_valid_i;
        end else if (rsp & drop_q) begin
            drop_d = 1'b0;
        end else if (rsp) begin
            valid_d  = 1'b1;
            instr_d  = icache_inst_i;
            out_pc_d = req_pc_q;
            err_d    = icache_error_i;
            pf_d     = icache_page_fault_i;
            halt_d   = icache_error_i | icache_page_fault_i;
        end else if (valid_q & fetch_accept_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= BOOT_PC;
            req_pc_q      <= '0;
            out_pc_q      <= '0;
            instr_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            halt_q        <= 1'b0;
            started_q     <= 1'b0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            pf_q          <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            out_pc_q      <= out_pc_d;
            instr_q       <= instr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halt_q        <= halt_d;
            started_q     <= started_d;
            valid_q       <= valid_d;
            err_q         <= err_d;
            pf_q          <= pf_d;
        end
    end

    assign icache_pc_o         = {pc_q[31:3], 3'b000};
    assign fetch_valid_o       = valid_q;
    assign fetch_instr_o       = instr_q;
    assign fetch_pc_o          = out_pc_q;
    assign fetch_fault_fetch_o = err_q;
    assign fetch_fault_page_o  = pf_q;
    assign fetch_pred_branch_o = 2'b00;
endmodule

// File: tb/tb_biriscv_fetch_issue.sv
// tb_biriscv_fetch_issue: acts as icache and decode, comparing every cycle against a
// transaction-level model (pending-request queue tagged with a redirect epoch).
module tb_biriscv_fetch_issue;
    localparam logic [31:0] BOOT = 32'h80000000;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        branch_request_i = 1'b0;
    logic [31:0] branch_pc_i = '0;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_accept_i = 1'b0, icache_valid_i = 1'b0;
    logic [63:0] icache_inst_i = '0;
    logic        icache_error_i = 1'b0, icache_page_fault_i = 1'b0;
    logic        fetch_valid_o;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_fetch_o, fetch_fault_page_o;
    logic [1:0]  fetch_pred_branch_o;
    logic        fetch_accept_i = 1'b0;

    biriscv_fetch_issue #(.BOOT_VECTOR(BOOT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i),
        .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o),
        .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
        .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
        .icache_page_fault_i(icache_page_fault_i),
        .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o(fetch_pc_o), .fetch_fault_fetch_o(fetch_fault_fetch_o),
        .fetch_fault_page_o(fetch_fault_page_o), .fetch_pred_branch_o(fetch_pred_branch_o),
        .fetch_accept_i(fetch_accept_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] data;
        logic        err;
        logic        pf;
        int          dly;
        int          ep;
    } req_t;

    req_t        pend[$];
    logic [31:0] m_pc = BOOT;
    bit          m_has, m_halt, m_started;
    int          m_ep;
    logic [31:0] b_pc;
    logic [63:0] b_instr;
    logic        b_err, b_pf;
    int          n_cmp, n_bad;
    int          lat_min, lat_max, fault_pct, stale_pct;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit br, input logic [31:0] tgt, input bit facc, input bit iacc);
        bit   exp_rd, dlv, fire;
        req_t r;
        @(negedge clk_i);
        branch_request_i    = br;
        branch_pc_i         = tgt;
        fetch_accept_i      = facc;
        icache_accept_i     = iacc;
        icache_inst_i       = {$urandom, $urandom};
        icache_valid_i      = 1'b0;
        icache_error_i      = 1'b0;
        icache_page_fault_i = 1'b0;
        dlv = pend.size() > 0 && pend[0].dly == 0;
        if (dlv) begin
            icache_valid_i      = 1'b1;
            icache_inst_i       = pend[0].data;
            icache_error_i      = pend[0].err;
            icache_page_fault_i = pend[0].pf;
        end else if (pend.size() == 0 && $urandom_range(0, 99) < stale_pct) begin
            icache_valid_i      = 1'b1;
            icache_error_i      = 1'($urandom_range(0, 1));
            icache_page_fault_i = 1'($urandom_range(0, 1));
        end
        #1;
        exp_rd = m_started && pend.size() == 0 && !m_halt && !br && (!m_has || facc);
        check("icache_rd", icache_rd_o, exp_rd);
        if (exp_rd) check("icache_pc", icache_pc_o, {m_pc[31:3], 3'b000});
        check("fetch_valid", fetch_valid_o, m_has);
        if (m_has) begin
            check("fetch_pc", fetch_pc_o, b_pc);
            check("fetch_instr", fetch_instr_o, b_instr);
            check("fault_fetch", fetch_fault_fetch_o, b_err);
            check("fault_page", fetch_fault_page_o, b_pf);
        end
        check("pred", fetch_pred_branch_o, 2'b00);
        fire = exp_rd && iacc;
        if (m_has && facc) m_has = 0;
        if (dlv) begin
            r = pend.pop_front();
            if (!br && r.ep == m_ep) begin
                m_has = 1; b_pc = r.pc; b_instr = r.data; b_err = r.err; b_pf = r.pf;
                if (r.err || r.pf) m_halt = 1;
            end
        end
        if (br) begin
            m_has = 0; m_ep++; m_pc = tgt; m_halt = 0;
        end
        foreach (pend[i]) pend[i].dly--;
        if (fire) begin
            r.pc   = m_pc;
            r.data = {$urandom, $urandom};
            r.err  = $urandom_range(0, 99) < fault_pct;
            r.pf   = $urandom_range(0, 99) < fault_pct;
            r.dly  = $urandom_range(lat_min, lat_max);
            r.ep   = m_ep;
            pend.push_back(r);
            m_pc = {m_pc[31:3], 3'b000} + 32'd8;
        end
        m_started = 1;
    endtask

    task automatic reset_checks();
        check("rst_valid", fetch_valid_o, 0);
        check("rst_rd", icache_rd_o, 0);
        check("rst_pc", fetch_pc_o, 0);
        check("rst_instr", fetch_instr_o, 0);
        check("rst_faults", {fetch_fault_fetch_o, fetch_fault_page_o}, 0);
    endtask

    task automatic do_reset();
        int sp;
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        icache_valid_i = 1'b1;
        #1 reset_checks();
        pend.delete();
        m_has = 0; m_halt = 0; m_started = 0; m_pc = BOOT; m_ep++;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        sp = stale_pct;
        stale_pct = 100;
        step(0, 0, 1, 1);
        stale_pct = sp;
    endtask

    initial begin
        logic [31:0] t;
        repeat (3) @(posedge clk_i);
        #1 reset_checks();
        rst_i = 1'b0;
        lat_min = 0; lat_max = 0; fault_pct = 0; stale_pct = 0;
        repeat (8) step(0, 0, 1, 1);
        for (int k = 0; k < 10 && !m_has; k++) step(0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 1);
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 10 && pend.size() != 1; k++) step(0, 0, 1, 1);
        step(1, 32'h80001004, 1, 1);
        repeat (8) step(0, 0, 1, 1);
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 10 && !(pend.size() == 1 && pend[0].dly == 0); k++) step(0, 0, 1, 1);
        step(1, 32'h80002000, 1, 1);
        repeat (6) step(0, 0, 1, 1);
        lat_min = 0; lat_max = 0; fault_pct = 100;
        for (int k = 0; k < 10 && !m_halt; k++) step(0, 0, 1, 1);
        fault_pct = 0;
        repeat (6) step(0, 0, 1, 1);
        step(1, 32'h80000100, 1, 1);
        repeat (6) step(0, 0, 1, 1);
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 10 && !(pend.size() == 1 && m_has); k++) step(0, 0, 0, 1);
        do_reset();
        repeat (6) step(0, 0, 1, 1);
        lat_min = 0; lat_max = 3; fault_pct = 5; stale_pct = 10;
        for (int k = 0; k < 3000; k++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            step($urandom_range(0, 11) == 0, t, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
            if (k == 1500) do_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/biriscv_fetch_issue.md
# biriscv_fetch_issue

Front-end fetch issuer that produces the 64-bit fetch bundles consumed by the decode stage's `fetch_in_*` interface.
- Generates instruction-cache read requests from an internal PC and captures the cache responses into a single-entry output register.
- Presents each captured bundle to decode with a valid/accept handshake.
- Handles pipeline redirects (`branch_request_i`) by discarding stale bundles and in-flight responses.
- Halts fetch after a fault until the next redirect.

## Interface
Parameters:
- BOOT_VECTOR, 32'h80000000, PC of the first fetch after reset (bits [2:0] ignored).

Ports:
- Reset `rst_i` is asynchronous, active-high; clock is `clk_i`.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- branch_request_i  in  1  redirect strobe (single cycle)
- branch_pc_i  in  32  redirect target
- icache_rd_o  out  1  cache read request
- icache_pc_o  out  32  request address, always {pc_q[31:3],3'b000}
- icache_accept_i  in  1  cache accepts request this cycle
- icache_valid_i  in  1  response valid
- icache_inst_i  in  64  response bundle, slot0 = [31:0]
- icache_error_i  in  1  bus error on response
- icache_page_fault_i  in  1  page fault on response
- fetch_valid_o  out  1  bundle valid to decode
- fetch_instr_o  out  64  bundle
- fetch_pc_o  out  32  bundle PC (full, bit 2 kept)
- fetch_fault_fetch_o  out  1  bundle carries bus error
- fetch_fault_page_o  out  1  bundle carries page fault
- fetch_pred_branch_o  out  2  bit0 = slot1 not valid; bit1 reserved 0
- fetch_accept_i  in  1  decode accepts bundle

## Operation
- **State registers:**
  - pc_q: reset BOOT_VECTOR.
  - outstanding_q: 0 = no request in flight.
  - drop_q: discard next response.
  - halt_q: stop fetching after a fault.
  - started_q: 0 until the first clock edge after reset.
  - Output register (valid, instr, pc, faults, pred): all 0 at reset.
- **Request:**
  - icache_rd_o = started_q & ~outstanding_q & ~halt_q & ~branch_request_i & (~fetch_valid_o | fetch_accept_i).
  - At most one outstanding request.
- **Request accepted** (icache_rd_o & icache_accept_i):
  - outstanding_q <= 1.
  - pc_q <= {pc_q[31:3],3'b000} + 8, wrapping modulo 2^32.
  - The request PC, including bit 2, is saved as req_pc_q.
- **Response** (icache_valid_i & outstanding_q):
  - outstanding_q <= 0.
  - If drop_q: discard the response and clear drop_q.
  - Otherwise load the output register: valid=1, instr=icache_inst_i, pc=req_pc_q, fault bits from the response.
    - pred[0] = 0.
    - If either fault bit is set: halt_q <= 1.
- **Handshake:** the bundle is transferred on fetch_valid_o & fetch_accept_i. On transfer the valid bit clears unless a new response loads in the same edge.
- **Output stability:** all fetch_* outputs hold stable while fetch_valid_o=1 and fetch_accept_i=0.
- **Redirect** (branch_request_i=1) has highest priority:
  - Output valid <= 0.
  - pc_q <= branch_pc_i, with bit 2 retained for req_pc_q.
  - halt_q <= 0.
  - If outstanding_q=1 and no response arrives this cycle: drop_q <= 1.
  - A response arriving in the redirect cycle is discarded and drop_q stays 0.
  - icache_rd_o is forced 0 in the redirect cycle.
- **Redirect to upper slot:** if the redirect target has bit 2 = 1, the first bundle is output with pc bit2=1. Decode uses fetch_pc_o to skip slot0.
- **Unexpected response:** icache_valid_i with outstanding_q=0 is ignored.

## Timing
- **Reset:**
  - icache_rd_o=0 while rst_i=1 and in the first cycle after release.
  - The first request (pc BOOT_VECTOR) is issued in the second cycle after release.
- **Latency:** request accepted in cycle N, response in cycle M>N, fetch_valid_o=1 in cycle M+1.
- **Throughput:**
  - The next request issues in cycle M+1 if the bundle is accepted that cycle, or if the output register is empty.
  - Peak rate with a 1-cycle cache is one bundle per 2 cycles.
- **Redirect timing:**
  - Redirect in cycle R: fetch_valid_o=0 in R+1.
  - If no request is outstanding: the request to branch_pc_i issues in R+1.
  - If a request is outstanding: issue follows the cycle after the dropped response.
- **Fault:** after a faulted bundle is loaded, no further requests issue until a redirect. The faulted bundle is still presented and must be accepted normally.

## Test plan
- **Boot:** release rst_i, cache always accepts with 1-cycle latency.
  - -> Requests at 0x80000000, 0x80000008, 0x80000010.
  - -> Bundles appear on fetch_* with matching pc, pred=2'b00.
- **Backpressure:** hold fetch_accept_i=0 for 5 cycles with a bundle at 0x80000008.
  - -> Outputs are stable and icache_rd_o=0.
  - -> On release, the next request to 0x80000010 issues in the same cycle.
- **Redirect while in flight:** request 0x80000010 accepted; branch_request_i with target 0x80001004 one cycle later; response arrives 2 cycles after.
  - -> Response is discarded.
  - -> Next request address is 0x80001000.
  - -> Bundle pc is 0x80001004.
- **Redirect coincident with response:** branch_request_i and icache_valid_i in the same cycle.
  - -> No bundle output, drop_q stays 0.
  - -> Request to the target issues the next cycle.
- **Fault halt:** response with icache_page_fault_i=1 at pc 0x80000020.
  - -> Bundle output with fetch_fault_page_o=1.
  - -> No icache_rd_o until branch_request_i to 0x80000100; fetch resumes there.
- **Mid-operation reset:** assert rst_i while a request is outstanding and a bundle is valid.
  - -> All outputs 0 immediately.
  - -> After release, the first request is at BOOT_VECTOR.
  - -> A stale icache_valid_i after reset is ignored.
